// File: rtl/pipe_sched.sv
// Pipeline scheduler for the 5-stage core: decides PC / step-1/2 register loads
// and bubble injection, sequencing load-use stalls, taken-branch flushes and
// end-of-program drain followed by halt.
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   pc_out                    current PC
//   id_rs1/id_rs2, id_uses_*  step-2 source registers and their use flags
//   ex_is_load, ex_rd         step-3 load flag and destination register
//   is_branch_step_4          taken branch resolved in step 4 this cycle
//   is_load_PC                PC register enable (combinational)
//   is_load_for_launch_1_2    step-1/2 register enable (combinational)
//   nop_step_2, nop_step_3    bubble injection (combinational)
//   halted                    program finished, pipeline empty (registered)
//   stall_cnt, flush_cnt      saturating performance counters (registered)
module pipe_sched #(
  parameter int unsigned WIDTH               = 32,
  parameter int unsigned INSTRACTION_NUMBERS = 16,
  parameter int unsigned BRANCH_BUBBLES      = 2,
  parameter int unsigned PIPE_DEPTH          = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc_out,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             is_branch_step_4,
  output logic             is_load_PC,
  output logic             is_load_for_launch_1_2,
  output logic             nop_step_2,
  output logic             nop_step_3,
  output logic             halted,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned CTR_W = 16;

  // cnt holds the number of sequence cycles still to come after the current
  // one, so the resolve / detection cycle counts as the first bubble.
  localparam logic [CNT_W-1:0] FLUSH_LOAD =
    CNT_W'((BRANCH_BUBBLES > 1) ? (BRANCH_BUBBLES - 2) : 0);
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    CNT_W'((PIPE_DEPTH > 2) ? (PIPE_DEPTH - 3) : 0);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_HALT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hazard;
  logic             prog_end;
  logic             take_branch;
  logic             take_stall;

  // Hazard / end detection and zero-latency control outputs.
  always_comb begin
    hazard   = ex_is_load && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
    prog_end = (pc_out >= WIDTH'(INSTRACTION_NUMBERS));

    take_branch            = 1'b0;
    take_stall             = 1'b0;
    is_load_PC             = 1'b0;
    is_load_for_launch_1_2 = 1'b0;
    nop_step_2             = 1'b1;
    nop_step_3             = 1'b0;

    if (reset_n) begin
      case (state)
        S_RUN: begin
          if (is_branch_step_4) begin
            is_load_PC  = 1'b1;
            take_branch = 1'b1;
          end else if (hazard) begin
            nop_step_2 = 1'b0;
            nop_step_3 = 1'b1;
            take_stall = 1'b1;
          end else if (!prog_end) begin
            is_load_PC             = 1'b1;
            is_load_for_launch_1_2 = 1'b1;
            nop_step_2             = 1'b0;
          end
        end
        S_FLUSH: is_load_PC = 1'b1;
        S_DRAIN: begin
          // An older in-flight branch hands control back to the program.
          if (is_branch_step_4) begin
            is_load_PC  = 1'b1;
            take_branch = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, shared sequence counter, halt flag and saturating counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_RUN;
      cnt       <= '0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (take_stall && (stall_cnt != CTR_MAX)) stall_cnt <= stall_cnt + CTR_W'(1);
      if (take_branch && (flush_cnt != CTR_MAX)) flush_cnt <= flush_cnt + CTR_W'(1);

      case (state)
        S_RUN: begin
          if (take_branch) begin
            if (BRANCH_BUBBLES > 1) begin
              state <= S_FLUSH;
              cnt   <= FLUSH_LOAD;
            end
          end else if (!hazard && prog_end) begin
            state <= S_DRAIN;
            cnt   <= DRAIN_LOAD;
          end
        end
        S_FLUSH: begin
          if (cnt == '0) state <= S_RUN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_DRAIN: begin
          if (take_branch) begin
            if (BRANCH_BUBBLES > 1) begin
              state <= S_FLUSH;
              cnt   <= FLUSH_LOAD;
            end else begin
              state <= S_RUN;
            end
          end else if (cnt == '0) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sched.sv
// Randomized scoreboard bench for pipe_sched: two instances (BRANCH_BUBBLES=2
// and 1) share stimulus; a behavioural model pushes expected per-cycle
// responses and a negedge monitor pops and compares them.
module tb_pipe_sched;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NINST = 16;
  localparam int unsigned PD    = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] pc_out;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_is_load, br;

  logic        pc_a, la_a, n2_a, n3_a, h_a;
  logic [15:0] sc_a, fc_a;
  logic        pc_b, la_b, n2_b, n3_b, h_b;
  logic [15:0] sc_b, fc_b;

  always #5 clk = ~clk;

  pipe_sched #(.WIDTH(WIDTH), .INSTRACTION_NUMBERS(NINST), .BRANCH_BUBBLES(2), .PIPE_DEPTH(PD)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .pc_out(pc_out),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .is_branch_step_4(br),
    .is_load_PC(pc_a), .is_load_for_launch_1_2(la_a), .nop_step_2(n2_a), .nop_step_3(n3_a),
    .halted(h_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

  pipe_sched #(.WIDTH(WIDTH), .INSTRACTION_NUMBERS(NINST), .BRANCH_BUBBLES(1), .PIPE_DEPTH(PD)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pc_out(pc_out),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .is_branch_step_4(br),
    .is_load_PC(pc_b), .is_load_for_launch_1_2(la_b), .nop_step_2(n2_b), .nop_step_3(n3_b),
    .halted(h_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

  typedef struct packed {
    logic        pc;
    logic        launch;
    logic        nop2;
    logic        nop3;
    logic        halted;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int vectors     = 0;
  int miscompares = 0;

  // Model state: remaining bubbles, remaining drain cycles, halt and counters.
  int          m_bub   [2];
  int          m_drain [2];
  bit          m_halt  [2];
  int unsigned m_stall [2];
  int unsigned m_flush [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bub[k] = 0; m_drain[k] = 0; m_halt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  // One cycle of the reference model for instance k; returns this cycle's expectation.
  task automatic model_step(input int k, output exp_t e);
    int  bb;
    bit  hz, pe;
    bb = (k == 0) ? 2 : 1;
    hz = ex_is_load && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    pe = (pc_out >= NINST);
    e.halted = m_halt[k];
    e.stall  = 16'(m_stall[k]);
    e.flush  = 16'(m_flush[k]);
    {e.pc, e.launch, e.nop2, e.nop3} = 4'b0010;
    if (!reset_n) begin
      m_bub[k] = 0; m_drain[k] = 0; m_halt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end else if (m_halt[k]) begin
      // everything ignored
    end else if (m_bub[k] > 0) begin
      e.pc = 1'b1;
      m_bub[k]--;
    end else if (m_drain[k] > 0) begin
      if (br) begin
        e.pc = 1'b1;
        if (m_flush[k] < 65535) m_flush[k]++;
        m_bub[k]   = bb - 1;
        m_drain[k] = 0;
      end else begin
        m_drain[k]--;
        if (m_drain[k] == 0) m_halt[k] = 1;
      end
    end else if (br) begin
      e.pc = 1'b1;
      if (m_flush[k] < 65535) m_flush[k]++;
      m_bub[k] = bb - 1;
    end else if (hz) begin
      {e.pc, e.launch, e.nop2, e.nop3} = 4'b0001;
      if (m_stall[k] < 65535) m_stall[k]++;
    end else if (pe) begin
      // detection cycle is the first of PD-1 drain cycles
      m_drain[k] = PD - 2;
    end else begin
      {e.pc, e.launch, e.nop2, e.nop3} = 4'b1100;
    end
  endtask

  // Apply the current inputs for one cycle and queue the expected response.
  task automatic issue();
    exp_t e0, e1;
    model_step(0, e0);
    model_step(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input int end_pct, input int br_pct);
    int r;
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    id_uses_rs1 = 1'($urandom_range(0, 1));
    id_uses_rs2 = 1'($urandom_range(0, 1));
    ex_is_load  = 1'($urandom_range(0, 1));
    br          = ($urandom_range(0, 99) < br_pct);
    r = $urandom_range(0, 99);
    if (r < end_pct) begin
      case ($urandom_range(0, 3))
        0: pc_out = 32'd16;
        1: pc_out = 32'd17;
        2: pc_out = 32'hFFFF_FFFF;
        default: pc_out = 32'($urandom_range(16, 1000));
      endcase
    end else begin
      pc_out = 32'($urandom_range(0, 15));
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t g;
    if (q0.size() != 0) begin
      exp_t e;
      e = q0.pop_front();
      g = '{pc: pc_a, launch: la_a, nop2: n2_a, nop3: n3_a, halted: h_a, stall: sc_a, flush: fc_a};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL bb2 t=%0t got pc=%b la=%b n2=%b n3=%b h=%b sc=%h fc=%h exp pc=%b la=%b n2=%b n3=%b h=%b sc=%h fc=%h",
                 $time, g.pc, g.launch, g.nop2, g.nop3, g.halted, g.stall, g.flush,
                 e.pc, e.launch, e.nop2, e.nop3, e.halted, e.stall, e.flush);
      end
    end
    if (q1.size() != 0) begin
      exp_t e;
      e = q1.pop_front();
      g = '{pc: pc_b, launch: la_b, nop2: n2_b, nop3: n3_b, halted: h_b, stall: sc_b, flush: fc_b};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL bb1 t=%0t got pc=%b la=%b n2=%b n3=%b h=%b sc=%h fc=%h exp pc=%b la=%b n2=%b n3=%b h=%b sc=%h fc=%h",
                 $time, g.pc, g.launch, g.nop2, g.nop3, g.halted, g.stall, g.flush,
                 e.pc, e.launch, e.nop2, e.nop3, e.halted, e.stall, e.flush);
      end
    end
  end

  initial begin
    reset_n = 1'b0; pc_out = '0; br = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
    model_reset();
    // Bring registers out of X before checking starts.
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed: load-use stall, then same with ex_rd = 0.
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    issue();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    issue();
    // Branch together with a hazard, then plain run.
    ex_rd = 5'd5; id_rs1 = 5'd5; br = 1'b1;
    issue();
    br = 1'b0; ex_is_load = 1'b0;
    repeat (3) issue();
    // Program end sweep with a branch in the 2nd drain cycle.
    pc_out = 32'd14; issue();
    pc_out = 32'd15; issue();
    pc_out = 32'd16; issue();
    issue();
    br = 1'b1; issue();
    br = 1'b0; pc_out = 32'd3; repeat (3) issue();
    // Drain to halt, then hazard and branch are ignored.
    pc_out = 32'd16; repeat (6) issue();
    ex_is_load = 1'b1; br = 1'b1; repeat (3) issue();
    // Reset in the first flush cycle.
    reset_n = 1'b0; br = 1'b0; issue();
    reset_n = 1'b1; ex_is_load = 1'b0; pc_out = 32'd2; br = 1'b1; issue();
    br = 1'b0; reset_n = 1'b0; issue();
    reset_n = 1'b1; repeat (2) issue();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rand_inputs(8, 15);
      reset_n = ($urandom_range(0, 59) != 0);
      if (m_halt[0] && m_halt[1] && $urandom_range(0, 3) == 0) reset_n = 1'b0;
      issue();
    end

    // Long hazard run to saturate the stall counter.
    reset_n = 1'b0; issue();
    reset_n = 1'b1; br = 1'b0; pc_out = 32'd1;
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_uses_rs1 = 1'b0;
    repeat (65540) issue();
    ex_is_load = 1'b0; repeat (2) issue();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
